// File: rtl/i2c_slave_regbank.sv
// i2c_slave_regbank: oversampled I2C slave with a pointer-addressed register bank
module i2c_slave_regbank #(
    parameter logic [6:0] SLV_ADDR    = 7'h27,
    parameter int         NUM_REGS    = 16,
    parameter int         REG_W       = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          scl_i,
    input  logic                          sda_i,
    output logic                          sda_oe,
    output logic [NUM_REGS*REG_W-1:0]     regs_flat,
    output logic                          wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0]   wr_idx,
    output logic                          busy
);
    localparam int PW = $clog2(NUM_REGS);
    localparam int NB = REG_W / 8;
    localparam int BW = $clog2(NB) + 1;
    localparam logic [3:0] IDLE = 4'd0, ADDR = 4'd1, ADDR_ACK = 4'd2, PTR = 4'd3, PTR_ACK = 4'd4,
                           WDATA = 4'd5, WDATA_ACK = 4'd6, RDATA = 4'd7, RDATA_ACK = 4'd8, IGNORE = 4'd9;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_d, sda_d, fall_d, scl_rise, scl_fall, start, stop, rx, mack;
    logic [3:0] state, bitcnt;
    logic [7:0] sr;
    logic [REG_W-1:0] stage, tx;
    logic [BW-1:0] bcnt;
    logic [PW-1:0] ptr, ptr_inc;
    logic [REG_W-1:0] regs [NUM_REGS];
    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start    = scl_s & scl_d & sda_d & ~sda_s;
    assign stop     = scl_s & scl_d & ~sda_d & sda_s;
    assign rx       = (state == ADDR) || (state == PTR) || (state == WDATA);
    assign ptr_inc  = (ptr == PW'(NUM_REGS - 1)) ? '0 : ptr + PW'(1);
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*REG_W +: REG_W] = regs[g];
    end
    // State advances on SCL falls; sda_oe follows one clk later so the master gets hold time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            fall_d   <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_pulse <= 1'b0;
            wr_idx   <= '0;
            ptr      <= '0;
            state    <= IDLE;
            bitcnt   <= 4'd7;
            bcnt     <= '0;
            sr       <= '0;
            stage    <= '0;
            tx       <= '0;
            mack     <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
            fall_d   <= scl_fall;
            wr_pulse <= 1'b0;
            if (start) begin
                state  <= ADDR;
                bitcnt <= 4'd7;
                bcnt   <= '0;
                sda_oe <= 1'b0;
            end else if (stop) begin
                state  <= IDLE;
                busy   <= 1'b0;
                bcnt   <= '0;
                sda_oe <= 1'b0;
            end else begin
                if (fall_d)
                    sda_oe <= (state == ADDR_ACK) || (state == PTR_ACK) || (state == WDATA_ACK) ||
                              ((state == RDATA) && !tx[REG_W-1]);
                if (scl_rise) begin
                    if (rx) sr <= {sr[6:0], sda_s};
                    if (rx || state == RDATA) bitcnt <= bitcnt - 4'd1;
                    if (state == RDATA_ACK) mack <= !sda_s;
                end
                // bitcnt[3] set means all 8 bits of the byte have been clocked
                if (scl_fall) begin
                    case (state)
                        ADDR: if (bitcnt[3]) begin
                            state <= (sr[7:1] == SLV_ADDR) ? ADDR_ACK : IGNORE;
                            if (sr[7:1] == SLV_ADDR) busy <= 1'b1;
                        end
                        ADDR_ACK: begin
                            state  <= sr[0] ? RDATA : PTR;
                            tx     <= regs[ptr];
                            bitcnt <= 4'd7;
                            bcnt   <= '0;
                        end
                        PTR: if (bitcnt[3]) begin
                            state <= (32'(sr) < NUM_REGS) ? PTR_ACK : IGNORE;
                            if (32'(sr) < NUM_REGS) ptr <= PW'(sr);
                        end
                        PTR_ACK: begin
                            state  <= WDATA;
                            bitcnt <= 4'd7;
                            bcnt   <= '0;
                        end
                        WDATA: if (bitcnt[3]) begin
                            stage <= (stage << 8) | REG_W'(sr);
                            bcnt  <= bcnt + BW'(1);
                            state <= WDATA_ACK;
                        end
                        WDATA_ACK: begin
                            state  <= WDATA;
                            bitcnt <= 4'd7;
                            if (bcnt == BW'(NB)) begin
                                regs[ptr] <= stage;
                                wr_pulse  <= 1'b1;
                                wr_idx    <= ptr;
                                ptr       <= ptr_inc;
                                bcnt      <= '0;
                            end
                        end
                        RDATA: begin
                            tx <= tx << 1;
                            if (bitcnt[3]) state <= RDATA_ACK;
                        end
                        RDATA_ACK: begin
                            state  <= mack ? RDATA : IGNORE;
                            bitcnt <= 4'd7;
                            bcnt   <= (bcnt == BW'(NB - 1)) ? '0 : bcnt + BW'(1);
                            if (bcnt == BW'(NB - 1)) begin
                                ptr <= ptr_inc;
                                tx  <= regs[ptr_inc];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule
